// File: rtl/imem_loader_if.sv
// Host-byte and instruction-memory bus of the instruction-memory loader.
// master = host/test side, slave = imem_loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              load_i;
  logic [ADDR_W:0]   len_i;
  logic              byte_valid_i;
  logic [7:0]        byte_i;
  logic              byte_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;
  logic              start_o;
  logic              busy_o;
  logic              error_o;

  modport master (
    output load_i, len_i, byte_valid_i, byte_i,
    input  byte_ready_o, mem_we_o, mem_addr_o, mem_data_o, start_o, busy_o, error_o
  );

  modport slave (
    input  load_i, len_i, byte_valid_i, byte_i,
    output byte_ready_o, mem_we_o, mem_addr_o, mem_data_o, start_o, busy_o, error_o
  );
endinterface

// File: rtl/imem_loader.sv
// Streams host bytes into instruction memory as big-endian words, then holds start_o.
// Optional IMEM_LOADER_CHECKSUM_EN: a trailing 32-bit sum word is verified before start_o.
//
// state | meaning
// IDLE  | after reset, waiting for load_i
// LOAD  | assembling and writing image words
// CHECK | receiving the checksum word (IMEM_LOADER_CHECKSUM_EN only)
// DONE  | image loaded, start_o held high
// ERR   | bad length or checksum mismatch, error_o held high
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input logic          clk_i,
  input logic          rst_i,
  imem_loader_if.slave bus
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wcnt;
  logic [ADDR_W-1:0] last_idx;
  logic [1:0]        bcnt;
  logic [23:0]       sh;
  logic              fin;
  logic              acc;
  logic              len_ok;
  logic [31:0]       word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       sum;
`endif

  assign acc    = bus.byte_valid_i & bus.byte_ready_o;
  assign len_ok = (bus.len_i != '0) && (bus.len_i <= LEN_MAX);
  assign word   = {sh, bus.byte_i};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state            <= IDLE;
      wcnt             <= '0;
      last_idx         <= '0;
      bcnt             <= '0;
      sh               <= '0;
      fin              <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum              <= '0;
`endif
      bus.byte_ready_o <= 1'b0;
      bus.mem_we_o     <= 1'b0;
      bus.mem_addr_o   <= '0;
      bus.mem_data_o   <= '0;
      bus.start_o      <= 1'b0;
      bus.busy_o       <= 1'b0;
      bus.error_o      <= 1'b0;
    end else begin
      bus.mem_we_o <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (bus.load_i) begin
            wcnt        <= '0;
            bcnt        <= '0;
            fin         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum         <= '0;
`endif
            bus.start_o <= 1'b0;
            if (len_ok) begin
              state            <= LOAD;
              last_idx         <= ADDR_W'(bus.len_i - 1'b1);
              bus.byte_ready_o <= 1'b1;
              bus.busy_o       <= 1'b1;
              bus.error_o      <= 1'b0;
            end else begin
              state            <= ERR;
              bus.byte_ready_o <= 1'b0;
              bus.busy_o       <= 1'b0;
              bus.error_o      <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (fin) begin
            state       <= DONE;
            bus.start_o <= 1'b1;
            bus.busy_o  <= 1'b0;
          end else if (acc) begin
            bcnt <= bcnt + 2'd1;
            sh   <= {sh[15:0], bus.byte_i};
            if (bcnt == 2'd3) begin
              bus.mem_we_o   <= 1'b1;
              bus.mem_addr_o <= wcnt;
              bus.mem_data_o <= word;
`ifdef IMEM_LOADER_CHECKSUM_EN
              sum            <= sum + word;
`endif
              // Counter stops at the last word so it can never wrap past len_i.
              if (wcnt == last_idx) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state            <= CHECK;
`else
                fin              <= 1'b1;
                bus.byte_ready_o <= 1'b0;
`endif
              end else begin
                wcnt <= wcnt + 1'b1;
              end
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (acc) begin
            bcnt <= bcnt + 2'd1;
            sh   <= {sh[15:0], bus.byte_i};
            if (bcnt == 2'd3) begin
              bus.byte_ready_o <= 1'b0;
              bus.busy_o       <= 1'b0;
              if (word == sum) begin
                state       <= DONE;
                bus.start_o <= 1'b1;
              end else begin
                state       <= ERR;
                bus.error_o <= 1'b1;
              end
            end
          end
        end
`endif

        default: begin
          state            <= IDLE;
          bus.byte_ready_o <= 1'b0;
          bus.busy_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven load vectors plus hand-written
// sequences for timing, full-depth, reset-abort and ignored-load corner cases.
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  always @(negedge clk_i) begin
    if (bus.mem_we_o) begin
      wr_addr.push_back(bus.mem_addr_o);
      wr_data.push_back(bus.mem_data_o);
    end
  end

  typedef struct {
    string      name;
    logic [8:0] len;
    int         nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic       exp_err;
    logic       exp_start;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.byte_valid_i = 1'b1;
    bus.byte_i       = b;
    for (int t = 0; t < 40; t++) begin
      if (bus.byte_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (!ok) chk("byte_accept_timeout", 32'(ok), 32'd1);
    @(negedge clk_i);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    int g;
    for (int k = 0; k < 4; k++) begin
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      if (g > 0) begin
        bus.byte_valid_i = 1'b0;
        repeat (g) @(negedge clk_i);
      end
      send_byte(w[31-8*k -: 8]);
    end
  endtask

  task automatic start_load(input logic [8:0] len);
    bus.byte_valid_i = 1'b0;
    bus.load_i       = 1'b1;
    bus.len_i        = len;
    @(negedge clk_i);
    bus.load_i       = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] s;
    clear_log();
    start_load(v.len);
    if (v.nw == 0) begin
      // Offer bytes anyway; none may be taken and nothing may be written.
      bus.byte_valid_i = 1'b1;
      bus.byte_i       = 8'h55;
      repeat (4) @(negedge clk_i);
    end
    if (v.nw > 0) send_word(v.w0, 0);
    if (v.nw > 1) send_word(v.w1, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    s = v.w0 + ((v.nw > 1) ? v.w1 : 32'd0);
    if (v.nw > 0) send_word(s, 0);
`else
    s = '0;
`endif
    bus.byte_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk({v.name, "_error"}, 32'(bus.error_o), 32'(v.exp_err));
    chk({v.name, "_start"}, 32'(bus.start_o), 32'(v.exp_start));
    chk({v.name, "_busy"},  32'(bus.busy_o),  32'd0);
    chk({v.name, "_nwrites"}, wr_addr.size(), v.nw);
    if (v.nw > 0 && wr_addr.size() > 0) begin
      chk({v.name, "_addr0"}, 32'(wr_addr[0]), 32'd0);
      chk({v.name, "_data0"}, wr_data[0], v.w0);
    end
    if (v.nw > 1 && wr_addr.size() > 1) begin
      chk({v.name, "_addr1"}, 32'(wr_addr[1]), 32'd1);
      chk({v.name, "_data1"}, wr_data[1], v.w1);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ready"}, 32'(bus.byte_ready_o), 32'd0);
    chk({name, "_we"},    32'(bus.mem_we_o),     32'd0);
    chk({name, "_start"}, 32'(bus.start_o),      32'd0);
    chk({name, "_busy"},  32'(bus.busy_o),       32'd0);
    chk({name, "_error"}, 32'(bus.error_o),      32'd0);
    chk({name, "_addr"},  32'(bus.mem_addr_o),   32'd0);
    chk({name, "_data"},  bus.mem_data_o,        32'd0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] sum;
    bus.load_i       = 1'b0;
    bus.len_i        = '0;
    bus.byte_valid_i = 1'b0;
    bus.byte_i       = '0;

    vecs[0] = '{"v_len2",   9'd2,   2, 32'h2008_0005, 32'h8C02_0004, 1'b0, 1'b1};
    vecs[1] = '{"v_len0",   9'd0,   0, 32'h0,         32'h0,         1'b1, 1'b0};
    vecs[2] = '{"v_len1",   9'd1,   1, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1};
    vecs[3] = '{"v_len257", 9'd257, 0, 32'h0,         32'h0,         1'b1, 1'b0};
    vecs[4] = '{"v_len1b",  9'd1,   1, 32'h1234_5678, 32'h0,         1'b0, 1'b1};
    vecs[5] = '{"v_len511", 9'd511, 0, 32'h0,         32'h0,         1'b1, 1'b0};

    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk_all_zero("idle");

    // Exact write/start timing for the reference two-word image.
    clear_log();
    start_load(9'd2);
    chk("seq034_busy",  32'(bus.busy_o),       32'd1);
    chk("seq034_ready", 32'(bus.byte_ready_o), 32'd1);
    send_word(32'h2008_0005, 0);
    chk("seq034_we0",   32'(bus.mem_we_o),   32'd1);
    chk("seq034_addr0", 32'(bus.mem_addr_o), 32'd0);
    chk("seq034_data0", bus.mem_data_o,      32'h2008_0005);
    send_word(32'h8C02_0004, 0);
    bus.byte_valid_i = 1'b0;
    chk("seq034_we1",   32'(bus.mem_we_o),   32'd1);
    chk("seq034_addr1", 32'(bus.mem_addr_o), 32'd1);
    chk("seq034_data1", bus.mem_data_o,      32'h8C02_0004);
`ifndef IMEM_LOADER_CHECKSUM_EN
    chk("seq034_start_not_yet", 32'(bus.start_o), 32'd0);
    @(negedge clk_i);
    chk("seq034_start", 32'(bus.start_o),      32'd1);
    chk("seq034_we_off", 32'(bus.mem_we_o),    32'd0);
    chk("seq034_hold_addr", 32'(bus.mem_addr_o), 32'd1);
    chk("seq034_hold_data", bus.mem_data_o,    32'h8C02_0004);
    chk("seq034_ready_done", 32'(bus.byte_ready_o), 32'd0);
`else
    send_word(32'h2008_0005 + 32'h8C02_0004, 0);
    bus.byte_valid_i = 1'b0;
    chk("seq034_start", 32'(bus.start_o), 32'd1);
`endif

    foreach (vecs[i]) run_vec(vecs[i]);

    // Full-depth image with random byte gaps.
    clear_log();
    sum = '0;
    start_load(9'd256);
    for (int i = 0; i < 256; i++) begin
      w = {i[7:0], i[7:0] ^ 8'hA5, ~i[7:0], 8'h3C};
      sum += w;
      send_word(w, 2);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(sum, 0);
`endif
    bus.byte_valid_i = 1'b1;
    bus.byte_i       = 8'hEE;
    repeat (6) @(negedge clk_i);
    bus.byte_valid_i = 1'b0;
    chk("full_nwrites", wr_addr.size(), 256);
    for (int i = 0; i < 256 && i < wr_addr.size(); i++) begin
      w = {i[7:0], i[7:0] ^ 8'hA5, ~i[7:0], 8'h3C};
      chk("full_addr", 32'(wr_addr[i]), i);
      chk("full_data", wr_data[i], w);
    end
    chk("full_start", 32'(bus.start_o), 32'd1);
    chk("full_error", 32'(bus.error_o), 32'd0);

    // Reset in the middle of the second word of a three-word load.
    clear_log();
    start_load(9'd3);
    send_word(32'hCAFE_0001, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_i = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk_i);
    rst_i = 1'b1;
    clear_log();
    bus.byte_valid_i = 1'b1;
    bus.byte_i       = 8'h33;
    repeat (8) @(negedge clk_i);
    bus.byte_valid_i = 1'b0;
    chk("rst_no_write", wr_addr.size(), 0);
    chk("rst_idle_ready", 32'(bus.byte_ready_o), 32'd0);
    start_load(9'd1);
    send_word(32'h0BAD_F00D, 0);
    bus.byte_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_fresh_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() > 0) begin
      chk("rst_fresh_addr", 32'(wr_addr[0]), 32'd0);
      chk("rst_fresh_data", wr_data[0], 32'h0BAD_F00D);
    end

    // load_i pulsed mid-load must be ignored.
    clear_log();
    start_load(9'd2);
    send_word(32'h0102_0304, 0);
    send_byte(8'hA1);
    bus.byte_valid_i = 1'b0;
    bus.load_i       = 1'b1;
    bus.len_i        = 9'd5;
    @(negedge clk_i);
    bus.load_i       = 1'b0;
    chk("ign_busy", 32'(bus.busy_o), 32'd1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'h0102_0304 + 32'hA1B2_C3D4, 0);
`endif
    bus.byte_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("ign_nwrites", wr_addr.size(), 2);
    if (wr_addr.size() > 1) begin
      chk("ign_addr1", 32'(wr_addr[1]), 32'd1);
      chk("ign_data1", wr_data[1], 32'hA1B2_C3D4);
    end
    chk("ign_start", 32'(bus.start_o), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    start_load(9'd2);
    send_word(32'h0000_0001, 0);
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'h0000_0000, 0);
    bus.byte_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("cks_ok_start", 32'(bus.start_o), 32'd1);
    chk("cks_ok_error", 32'(bus.error_o), 32'd0);
    start_load(9'd2);
    send_word(32'h0000_0001, 0);
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'h0000_0001, 0);
    bus.byte_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("cks_bad_start", 32'(bus.start_o), 32'd0);
    chk("cks_bad_error", 32'(bus.error_o), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, 256, instruction memory depth in 32-bit words.
REQ-002 Parameter: ADDR_W, 8, word-address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 clk_i  input  1  single clock, all state on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous assert, active-low.
REQ-005 load_i  input  1  one-cycle request to begin a load.
REQ-006 len_i  input  ADDR_W+1  word count to load, sampled when load_i is accepted.
REQ-007 byte_valid_i  input  1  host byte present.
REQ-008 byte_i  input  8  host byte.
REQ-009 byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-010 mem_we_o  output  1  instruction-memory word write strobe.
REQ-011 mem_addr_o  output  ADDR_W  word address of the write.
REQ-012 mem_data_o  output  32  word written.
REQ-013 start_o  output  1  level; drives CPU start_i once the image is loaded.
REQ-014 busy_o  output  1  load in progress.
REQ-015 error_o  output  1  sticky load failure.

Function
REQ-016 States SHALL be IDLE, LOAD, CHECK, DONE, ERR; busy_o=1 in LOAD and CHECK only.
REQ-017 IDLE: load_i=1 with 1<=len_i<=DEPTH -> LOAD, word counter=0, byte counter=0; len_i=0 or >DEPTH -> ERR.
REQ-018 A byte SHALL be accepted on a rising edge where byte_valid_i && byte_ready_o; byte_ready_o=1 in LOAD and CHECK, else 0.
REQ-019 Bytes SHALL assemble big-endian: first accepted byte -> bits 31:24, fourth -> bits 7:0.
REQ-020 The cycle after the 4th byte of a word is accepted, mem_we_o SHALL be 1 for exactly one cycle with mem_addr_o=word counter and mem_data_o=assembled word; word counter then increments.
REQ-021 Byte acceptance SHALL continue back-to-back; a new byte in the write cycle is accepted without stall.
REQ-022 After word len_i-1 is written: -> CHECK if checksum enabled (REQ-032), else -> DONE.
REQ-023 Word counter SHALL never wrap; no write occurs at addresses >= len_i.
REQ-024 DONE: start_o=1 continuously, byte_ready_o=0, mem_we_o=0.
REQ-025 ERR: error_o=1, start_o=0, byte_ready_o=0.
REQ-026 load_i in LOAD or CHECK SHALL be ignored.
REQ-027 load_i in DONE or ERR SHALL restart per REQ-017; start_o and error_o deassert on that edge.
REQ-028 mem_addr_o and mem_data_o SHALL hold last written values when mem_we_o=0.

Reset
REQ-029 rst_i=0 SHALL immediately force IDLE and drive byte_ready_o, mem_we_o, start_o, busy_o, error_o, mem_addr_o, mem_data_o to 0.
REQ-030 Reset mid-load SHALL discard the partial word and counters; no write issues after reset release until a new load_i.
REQ-031 Outputs SHALL be 0 in IDLE after reset until load_i.

Configuration
REQ-032 Macro IMEM_LOADER_CHECKSUM_EN defined: loader keeps a 32-bit modulo-2^32 sum of all written words; in CHECK it accepts one further 4-byte big-endian word (not written to memory); match -> DONE, mismatch -> ERR, one cycle after 4th byte.
REQ-033 Macro undefined: no checksum logic, CHECK state unreachable, LOAD goes directly to DONE the cycle after the last write.

Verification
REQ-034 Reset, load_i with len_i=2, bytes 20 08 00 05 8C 02 00 04 continuous -> writes addr0=0x20080005, addr1=0x8C020004, one cycle after each 4th byte; start_o=1 next cycle.
REQ-035 len_i=0 and len_i=257 -> error_o=1, start_o=0, no mem_we_o; subsequent load_i len_i=1 clears error_o.
REQ-036 len_i=256, random byte_valid_i gaps -> 256 writes, addresses 0..255 in order, no write beyond 255, start_o=1 after last.
REQ-037 rst_i low after 6 bytes of len_i=3 -> all outputs 0 immediately; after release no mem_we_o until load_i; fresh load writes from addr 0.
REQ-038 IMEM_LOADER_CHECKSUM_EN, words 0x00000001, 0xFFFFFFFF, checksum 0x00000000 -> start_o=1; checksum 0x00000001 -> error_o=1, start_o=0.
REQ-039 load_i pulsed mid-LOAD -> ignored, counters unchanged, load completes normally.
